// File: rtl/pio_key_debounce.sv
// -----------------------------------------------------------------------------
// pio_key_debounce
//
// Conditions raw push-button pins before they reach the HPS button PIO export.
// Each channel is handled independently:
//   raw pin -> 2-flop synchronizer -> polarity normalisation -> counter-based
//   debounce -> debounced "pressed" level plus one-cycle press/release pulses.
//
// A new level is accepted only after it has been seen on DEBOUNCE_CYCLES
// consecutive clocks. Any excursion shorter than that is discarded completely.
// No partial credit survives a bounce.
//
// Parameters:
//   NUM_KEYS        number of independent key channels
//   CNT_W           width of each debounce counter
//   DEBOUNCE_CYCLES stable cycles needed to accept a new level,
//                   legal range 2 .. 2**CNT_W-1
//   KEY_ACTIVE_LOW  1: pin reads 0 when pressed, 0: pin reads 1 when pressed
//
// Ports:
//   clk_clk        system clock (50 MHz)
//   reset_reset_n  asynchronous active-low reset
//   key_raw        asynchronous raw button pins
//   key_db         debounced level, active-high "pressed"
//   press_pulse    one-cycle pulse when key_db rises
//   release_pulse  one-cycle pulse when key_db falls
//   any_pressed    OR of key_db
// -----------------------------------------------------------------------------
module pio_key_debounce #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_db,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic                any_pressed
);

    // Raw pin level of a released key; the synchronizer resets to it so that
    // reset release never looks like a key edge.
    localparam logic [NUM_KEYS-1:0] INACTIVE_LVL = {NUM_KEYS{KEY_ACTIVE_LOW}};

    // Counter value on the clock edge that accepts the new level.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    // A channel is STABLE while its synchronized level matches key_db and
    // COUNTING while it disagrees. The classification is derived each cycle
    // from registered values, so it needs no state register of its own.
    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } ch_state_e;

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] pressed_s;

    logic [CNT_W-1:0]    cnt     [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_nxt [NUM_KEYS];
    logic [NUM_KEYS-1:0] db_nxt;
    logic [NUM_KEYS-1:0] press_nxt;
    logic [NUM_KEYS-1:0] release_nxt;
    ch_state_e           ch_state [NUM_KEYS];

    // -------------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous pins.
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // two synchronizer stages into one.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1 <= INACTIVE_LVL;
            sync2 <= INACTIVE_LVL;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // From here on everything is active-high "pressed".
    assign pressed_s = sync2 ^ INACTIVE_LVL;

    // -------------------------------------------------------------------------
    // Next-state logic for all channels.
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        db_nxt      = key_db;
        press_nxt   = '0;
        release_nxt = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_nxt[i]  = '0;
            ch_state[i] = (pressed_s[i] != key_db[i]) ? COUNTING : STABLE;

            unique case (ch_state[i])
                STABLE: begin
                    // Also covers a bounce back to the accepted level: the
                    // count restarts from zero on the next disagreement.
                    cnt_nxt[i] = '0;
                end
                COUNTING: begin
                    if (cnt[i] == LAST_CNT) begin
                        // Acceptance resets the counter, so it never wraps.
                        db_nxt[i]      = pressed_s[i];
                        press_nxt[i]   = pressed_s[i];
                        release_nxt[i] = ~pressed_s[i];
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: cnt_nxt[i] = '0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Debounce state registers.
    // -------------------------------------------------------------------------
    // NOTE: the counter array is reset explicitly. It is a handful of flops,
    // not a RAM, and counting must restart from zero after any reset,
    // including one that arrives mid-count.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= '0;
            end
            key_db        <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            key_db        <= db_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    // OR of registered levels: no extra latency relative to key_db.
    assign any_pressed = |key_db;

endmodule

// File: tb/tb_pio_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_pio_key_debounce
//
// Drives two instances of pio_key_debounce with DEBOUNCE_CYCLES=8 and CNT_W=4:
//   inst 0: KEY_ACTIVE_LOW=1
//   inst 1: KEY_ACTIVE_LOW=0
//
// The reference model takes the view "a level is accepted when the last
// DEBOUNCE_CYCLES synchronized samples all disagree with the current
// debounced level". Synchronized samples are the raw pin delayed by two edges.
// -----------------------------------------------------------------------------
module tb_pio_key_debounce;

    localparam int NK = 4;
    localparam int CW = 4;
    localparam int DC = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] raw [2];
    logic [NK-1:0] db  [2];
    logic [NK-1:0] pp  [2];
    logic [NK-1:0] rp  [2];
    logic          ap  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_key_debounce #(
        .NUM_KEYS(NK), .CNT_W(CW), .DEBOUNCE_CYCLES(DC), .KEY_ACTIVE_LOW(1'b1)
    ) u_dut_al (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .key_raw       (raw[0]),
        .key_db        (db[0]),
        .press_pulse   (pp[0]),
        .release_pulse (rp[0]),
        .any_pressed   (ap[0])
    );

    pio_key_debounce #(
        .NUM_KEYS(NK), .CNT_W(CW), .DEBOUNCE_CYCLES(DC), .KEY_ACTIVE_LOW(1'b0)
    ) u_dut_ah (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .key_raw       (raw[1]),
        .key_db        (db[1]),
        .press_pulse   (pp[1]),
        .release_pulse (rp[1]),
        .any_pressed   (ap[1])
    );

    // -------------------------------------------------------------------------
    // Check helper
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [NK-1:0] act,
                         input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [NK-1:0] m_db  [2];
    logic [NK-1:0] m_pp  [2];
    logic [NK-1:0] m_rp  [2];
    logic [NK-1:0] rdly  [2][2];   // raw pin delayed by 1 and 2 edges
    logic [NK-1:0] hist  [2][DC];  // normalised samples, index 0 newest

    function automatic logic [NK-1:0] idle_lvl(input int g);
        return (g == 0) ? {NK{1'b1}} : {NK{1'b0}};
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            m_db[g]    = '0;
            m_pp[g]    = '0;
            m_rp[g]    = '0;
            rdly[g][0] = idle_lvl(g);
            rdly[g][1] = idle_lvl(g);
            for (int i = 0; i < DC; i++) hist[g][i] = '0;
        end
    endtask

    task automatic model_step();
        logic [NK-1:0] flip;
        for (int g = 0; g < 2; g++) begin
            for (int i = DC - 1; i > 0; i--) hist[g][i] = hist[g][i-1];
            hist[g][0] = rdly[g][1] ^ idle_lvl(g);
            rdly[g][1] = rdly[g][0];
            rdly[g][0] = raw[g];
            flip = '1;
            for (int i = 0; i < DC; i++) flip &= hist[g][i] ^ m_db[g];
            m_pp[g] = flip & ~m_db[g];
            m_rp[g] = flip &  m_db[g];
            m_db[g] = m_db[g] ^ flip;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                check($sformatf("model_db%0d", g), db[g], m_db[g]);
                check($sformatf("model_press%0d", g), pp[g], m_pp[g]);
                check($sformatf("model_release%0d", g), rp[g], m_rp[g]);
                check($sformatf("model_any%0d", g), {3'b000, ap[g]},
                      {3'b000, |m_db[g]});
            end
        end
    end

    // Global time limit.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // -------------------------------------------------------------------------
    // Directed helpers
    // -------------------------------------------------------------------------
    task automatic drive(input int g, input logic [NK-1:0] v);
        @(negedge clk);
        raw[g] = v;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        raw[0] = 4'hF;
        raw[1] = 4'h0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_db", db[0], 4'h0);
        check("rst_press", pp[0], 4'h0);
        check("rst_release", rp[0], 4'h0);
        check("rst_any", {3'b000, ap[0]}, 4'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: single press, accepted on the 10th edge after the pin change.
        drive(0, 4'hE);
        edges(9);
        check("t1_db_early", db[0], 4'h0);
        edges(1);
        check("t1_db", db[0], 4'h1);
        check("t1_press", pp[0], 4'h1);
        check("t1_any", {3'b000, ap[0]}, 4'h1);
        edges(1);
        check("t1_press_one_cycle", pp[0], 4'h0);
        drive(0, 4'hF);
        edges(10);
        check("t1_release", rp[0], 4'h1);
        check("t1_db_released", db[0], 4'h0);
        repeat (4) @(negedge clk);

        // 2: bounce on key 1, 3-cycle runs for 30 cycles, then held.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            raw[0][1] = (k % 2 == 1);
            repeat (2) @(negedge clk);
        end
        check("t2_db_bouncing", db[0], 4'h0);
        drive(0, 4'hD);
        edges(9);
        check("t2_db_early", db[0], 4'h0);
        edges(1);
        check("t2_db", db[0], 4'h2);
        check("t2_press", pp[0], 4'h2);
        drive(0, 4'hF);
        edges(12);

        // 3: 7-cycle glitch rejected, 8-cycle excursion accepted.
        drive(0, 4'hB);
        repeat (7) @(negedge clk);
        raw[0] = 4'hF;
        edges(12);
        check("t3_glitch7_db", db[0], 4'h0);
        drive(0, 4'hB);
        repeat (8) @(negedge clk);
        raw[0] = 4'hF;
        edges(9);
        check("t3_glitch8_db", db[0], 4'h4);
        edges(1);
        check("t3_glitch8_fall", db[0], 4'h0);
        check("t3_glitch8_release", rp[0], 4'h4);
        repeat (4) @(negedge clk);

        // 4: all keys together.
        drive(0, 4'h0);
        edges(10);
        check("t4_db", db[0], 4'hF);
        check("t4_press", pp[0], 4'hF);
        drive(0, 4'hF);
        edges(10);
        check("t4_release", rp[0], 4'hF);
        check("t4_db_released", db[0], 4'h0);
        repeat (4) @(negedge clk);

        // 5: asynchronous reset mid-count with key 3 held.
        drive(0, 4'h7);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_db", db[0], 4'h0);
        check("t5_rst_press", pp[0], 4'h0);
        check("t5_rst_any", {3'b000, ap[0]}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        edges(9);
        check("t5_db_early", db[0], 4'h0);
        edges(1);
        check("t5_db", db[0], 4'h8);
        check("t5_press", pp[0], 4'h8);
        drive(0, 4'hF);
        edges(12);

        // 6: active-high instance.
        drive(1, 4'h1);
        edges(9);
        check("t6_db_early", db[1], 4'h0);
        edges(1);
        check("t6_db", db[1], 4'h1);
        check("t6_press", pp[1], 4'h1);
        drive(1, 4'h0);
        edges(10);
        check("t6_release", rp[1], 4'h1);
        repeat (4) @(negedge clk);

        // Random: each bit toggles with probability 1/10 per cycle.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                for (int b = 0; b < NK; b++) begin
                    if ($urandom_range(0, 9) == 0) raw[g][b] = ~raw[g][b];
                end
            end
            if (k == 1500) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        edges(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
